clock_set_sequencer: RTL and testbench
======================================

// Module: clock_set_sequencer
// PURPOSE
//  Front-panel controller for the digital clock. Owns the display/set mode FSM and
//  turns the debounced MODE and ADD keys into single-cycle increment requests for the
//  minute/hour/day/month counters, including hold-to-auto-repeat and an idle timeout.
//  Drives the seconds-chain run enable, the status code and the per-digit enable mask
//  used by the segment scanner.
// PARAMETERS
//  HOLD_TICKS    50    tick_10ms pulses ADD must be held before auto-repeat starts (500 ms)
//  REPEAT_TICKS  10    tick_10ms pulses between auto-repeat increments (100 ms)
//  TIMEOUT_TICKS 1000  tick_10ms pulses with no key press in a set state before returning to RUN (10 s)
//  BLINK_TICKS   25    tick_10ms pulses per blink half-period (used only with CLOCK_SET_BLINK_EN)
// PORTS
//  clock        in   1  system clock
//  reset        in   1  asynchronous reset, active-high
//  tick_10ms    in   1  one-cycle timebase pulse, every 10 ms
//  key_mode_n   in   1  debounced MODE key level, 0 = pressed
//  key_add_n    in   1  debounced ADD key level, 0 = pressed
//  status       out  3  0=RUN 1=SET_HOUR 2=SET_MIN 3=SET_MONTH 4=SET_DAY
//  run_en       out  1  1 = seconds chain counts
//  sec_clear    out  1  one-cycle pulse: clear seconds and sub-second divider
//  inc_minute   out  1  one-cycle increment request
//  inc_hour     out  1  one-cycle increment request
//  inc_day      out  1  one-cycle increment request
//  inc_month    out  1  one-cycle increment request
//  digit_mask   out  4  per-digit display enable, [3:2] = left pair, [1:0] = right pair
// BEHAVIOUR
//  Reset (async, active-high): status=RUN, run_en=1, all pulses=0, digit_mask=4'b1111.
//   Key history regs=1 (released); hold, repeat, timeout and blink counters=0; dirty=0.
//  Press detect: key history registered each clock; press = prev 1 and now 0.
//   Press pulse appears one cycle after the level falls.
//  FSM: MODE press advances RUN->SET_HOUR->SET_MIN->SET_MONTH->SET_DAY->RUN.
//   The next state is visible on status on the clock edge after the press pulse.
//  ADD in RUN: ignored; no pulses; run_en stays 1.
//  ADD in a set state: press pulse -> exactly one inc_* pulse on the next clock, selected
//   by the current state. Also sets dirty=1, run_en=0, and clears the hold counter.
//  Auto-repeat: while ADD is held, count tick_10ms. At HOLD_TICKS, issue one inc pulse.
//   Then issue one inc pulse every REPEAT_TICKS ticks until ADD is released.
//  At most one inc_* asserted in any cycle; inc_* never asserted in RUN.
//  Leaving to RUN (MODE wrap or timeout): status=RUN and run_en=1 on the same edge.
//   If dirty, sec_clear pulses for 1 cycle on that edge; dirty then clears.
//  Timeout: counter cleared by any press pulse and held at 0 in RUN. Counts tick_10ms in
//   set states. Reaching TIMEOUT_TICKS forces RUN as above. A held key is not activity.
//  Simultaneous MODE and ADD press: MODE wins, no inc pulse, hold counter cleared.
//  MODE press while ADD held: auto-repeat stops until ADD is released and pressed again.
//  Counters: width $clog2(max param + 1); saturate, never wrap.
//  digit_mask by state: RUN 1111, SET_HOUR 1100, SET_MIN 0011, SET_MONTH 1100, SET_DAY 0011.
//  Reset asserted mid-hold or mid-timeout: everything returns to reset values immediately.
//   After release, a still-held ADD does not count as a press.
// CONFIGURATION
//  CLOCK_SET_BLINK_EN defined: in set states a phase bit toggles every BLINK_TICKS ticks.
//   During the off phase the selected digits are forced to 0 in digit_mask.
//   Phase is forced on while ADD is held and resets to on at each state change.
//   RUN is unaffected.
//  Not defined: no blink logic, BLINK_TICKS unused, digit_mask is the static table above.
// TESTING
//  T1 reset: reset=1 -> status=0, run_en=1, digit_mask=1111, all inc_*/sec_clear=0.
//  T2 mode walk: 5 MODE presses -> status 1,2,3,4,0. No inc_*. sec_clear never pulses (dirty=0).
//  T3 set minute: MODE x2, ADD tap -> one inc_minute pulse, run_en=0.
//   MODE x3 -> status=0, run_en=1, one sec_clear pulse.
//  T4 auto-repeat: SET_HOUR, hold ADD 120 ticks -> inc_hour at press, then at tick 50,
//   60 ... 120 (9 pulses total). Release -> no further pulses.
//  T5 timeout: SET_DAY, 1 ADD tap, idle 1000 ticks -> status=0 on tick 1000.
//   sec_clear pulses once, inc_day count = 1.
//  T6 conflict/reset: MODE and ADD fall on the same cycle -> state advances, no inc.
//   Reset during a held ADD -> no inc after reset release until a new press.

Source files
------------

// File: rtl/clock_set_sequencer_if.sv
// rtl/clock_set_sequencer_if.sv - front-panel key/timebase inputs and set-mode outputs
//
// Purpose: bundles the key levels, the 10 ms timebase and every output of
//          clock_set_sequencer into one interface.
// Modports:
//   slave  - the sequencer: receives tick_10ms/key_*_n, drives all other signals
//   master - the panel side: drives tick_10ms/key_*_n, observes all other signals
// Signals:
//   tick_10ms   1  one-cycle timebase pulse, every 10 ms
//   key_mode_n  1  debounced MODE key level, 0 = pressed
//   key_add_n   1  debounced ADD key level, 0 = pressed
//   status      3  0=RUN 1=SET_HOUR 2=SET_MIN 3=SET_MONTH 4=SET_DAY
//   run_en      1  1 = seconds chain counts
//   sec_clear   1  one-cycle pulse: clear seconds and sub-second divider
//   inc_minute  1  one-cycle increment request
//   inc_hour    1  one-cycle increment request
//   inc_day     1  one-cycle increment request
//   inc_month   1  one-cycle increment request
//   digit_mask  4  per-digit display enable, [3:2] = left pair, [1:0] = right pair
`timescale 1ns/1ps
interface clock_set_sequencer_if;
   logic       tick_10ms;
   logic       key_mode_n;
   logic       key_add_n;
   logic [2:0] status;
   logic       run_en;
   logic       sec_clear;
   logic       inc_minute;
   logic       inc_hour;
   logic       inc_day;
   logic       inc_month;
   logic [3:0] digit_mask;

   modport slave (
      input  tick_10ms, key_mode_n, key_add_n,
      output status, run_en, sec_clear, inc_minute, inc_hour, inc_day, inc_month, digit_mask
   );

   modport master (
      output tick_10ms, key_mode_n, key_add_n,
      input  status, run_en, sec_clear, inc_minute, inc_hour, inc_day, inc_month, digit_mask
   );
endinterface

// File: rtl/clock_set_sequencer.sv
// rtl/clock_set_sequencer.sv - display/set mode controller for the digital clock front panel
//
// Purpose: turns debounced MODE/ADD key levels into the set-mode FSM, single-cycle
//          minute/hour/day/month increment requests (with hold-to-auto-repeat),
//          an idle timeout back to RUN, the seconds run enable, the status code and
//          the per-digit display enable mask.
// Ports:
//   clock  in  system clock
//   reset  in  asynchronous reset, active-high
//   bus    clock_set_sequencer_if.slave (tick_10ms, key_mode_n, key_add_n in;
//          status, run_en, sec_clear, inc_*, digit_mask out)
// Optional feature macro: CLOCK_SET_BLINK_EN (blinks the digits being set).
`timescale 1ns/1ps
module clock_set_sequencer #(
   parameter int HOLD_TICKS    = 50,
   parameter int REPEAT_TICKS  = 10,
   parameter int TIMEOUT_TICKS = 1000,
   parameter int BLINK_TICKS   = 25
) (
   input logic                  clock,
   input logic                  reset,
   clock_set_sequencer_if.slave bus
);

   localparam int MAX_HR  = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
   localparam int MAX_TB  = (TIMEOUT_TICKS > BLINK_TICKS) ? TIMEOUT_TICKS : BLINK_TICKS;
   localparam int MAX_ALL = (MAX_HR > MAX_TB) ? MAX_HR : MAX_TB;
   localparam int CW      = $clog2(MAX_ALL + 1);

   localparam logic [CW-1:0] HOLD_C = CW'(HOLD_TICKS);
   localparam logic [CW-1:0] HOLD_M1 = CW'(HOLD_TICKS - 1);
   localparam logic [CW-1:0] REP_M1 = CW'(REPEAT_TICKS - 1);
   localparam logic [CW-1:0] TMO_M1 = CW'(TIMEOUT_TICKS - 1);
`ifdef CLOCK_SET_BLINK_EN
   localparam logic [CW-1:0] BLK_M1 = CW'(BLINK_TICKS - 1);
`endif

   typedef enum logic [2:0] {
      S_RUN   = 3'd0,
      S_HOUR  = 3'd1,
      S_MIN   = 3'd2,
      S_MONTH = 3'd3,
      S_DAY   = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic          mode_d1, mode_d2, add_d1, add_d2;
   logic          mode_arm_q, add_arm_q;
   logic [CW-1:0] hold_q, hold_d;
   logic [CW-1:0] rep_q, rep_d;
   logic [CW-1:0] tmo_q, tmo_d;
   logic          rep_en_q, rep_en_d;
   logic          dirty_q, dirty_d;
   logic          run_en_q, run_en_d;
   logic          sec_clear_q, sec_clear_d;
   logic [3:0]    inc_q, inc_d;        // {month, day, hour, minute}
   logic [3:0]    sel_inc;
   logic [3:0]    mask_tbl;
   logic [3:0]    mask_out;
   logic          mode_press, add_press, add_held, in_set, go_run;
`ifdef CLOCK_SET_BLINK_EN
   logic          phase_q, phase_d;
   logic [CW-1:0] blink_q, blink_d;
`endif

   // A key only produces a press once it has been seen released since reset,
   // so a key still held across reset release is not mistaken for a new press.
   assign mode_press = mode_arm_q & mode_d2 & ~mode_d1;
   assign add_press  = add_arm_q & add_d2 & ~add_d1;
   assign add_held   = ~add_d1;
   assign in_set     = (state_q != S_RUN);

   always_comb begin
      sel_inc  = 4'b0000;
      mask_tbl = 4'b1111;
      case (state_q)
         S_HOUR:  begin sel_inc = 4'b0010; mask_tbl = 4'b1100; end
         S_MIN:   begin sel_inc = 4'b0001; mask_tbl = 4'b0011; end
         S_MONTH: begin sel_inc = 4'b1000; mask_tbl = 4'b1100; end
         S_DAY:   begin sel_inc = 4'b0100; mask_tbl = 4'b0011; end
         default: begin sel_inc = 4'b0000; mask_tbl = 4'b1111; end
      endcase
   end

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      rep_d       = rep_q;
      tmo_d       = tmo_q;
      rep_en_d    = rep_en_q & add_held;   // releasing ADD always ends auto-repeat
      dirty_d     = dirty_q;
      run_en_d    = run_en_q;
      sec_clear_d = 1'b0;
      inc_d       = 4'b0000;
      go_run      = 1'b0;

      if (mode_press) begin
         // MODE wins over a simultaneous ADD and also cancels any running auto-repeat.
         hold_d   = '0;
         rep_d    = '0;
         rep_en_d = 1'b0;
         tmo_d    = '0;
         case (state_q)
            S_RUN:   state_d = S_HOUR;
            S_HOUR:  state_d = S_MIN;
            S_MIN:   state_d = S_MONTH;
            S_MONTH: state_d = S_DAY;
            default: go_run  = 1'b1;
         endcase
      end else if (in_set) begin
         if (add_press) begin
            inc_d    = sel_inc;
            dirty_d  = 1'b1;
            run_en_d = 1'b0;
            hold_d   = '0;
            rep_d    = '0;
            rep_en_d = 1'b1;
            tmo_d    = '0;
         end else if (bus.tick_10ms) begin
            if (tmo_q >= TMO_M1) begin
               go_run = 1'b1;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
            if (rep_en_q && add_held) begin
               if (hold_q < HOLD_C) begin
                  hold_d = hold_q + 1'b1;
                  if (hold_q == HOLD_M1) begin
                     inc_d = sel_inc;
                     rep_d = '0;
                  end
               end else if (rep_q >= REP_M1) begin
                  inc_d = sel_inc;
                  rep_d = '0;
               end else begin
                  rep_d = rep_q + 1'b1;
               end
            end
         end
      end

      if (go_run) begin
         // Entering RUN never carries an increment with it.
         state_d     = S_RUN;
         run_en_d    = 1'b1;
         sec_clear_d = dirty_q;
         dirty_d     = 1'b0;
         tmo_d       = '0;
         hold_d      = '0;
         rep_d       = '0;
         rep_en_d    = 1'b0;
         inc_d       = 4'b0000;
      end
   end

`ifdef CLOCK_SET_BLINK_EN
   always_comb begin
      phase_d = phase_q;
      blink_d = blink_q;
      if ((state_d != state_q) || !in_set || add_held) begin
         phase_d = 1'b1;
         blink_d = '0;
      end else if (bus.tick_10ms) begin
         if (blink_q >= BLK_M1) begin
            phase_d = ~phase_q;
            blink_d = '0;
         end else begin
            blink_d = blink_q + 1'b1;
         end
      end
   end

   assign mask_out = (!in_set || phase_q) ? mask_tbl : 4'b0000;
`else
   assign mask_out = mask_tbl;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= S_RUN;
         mode_d1     <= 1'b1;
         mode_d2     <= 1'b1;
         add_d1      <= 1'b1;
         add_d2      <= 1'b1;
         mode_arm_q  <= 1'b0;
         add_arm_q   <= 1'b0;
         hold_q      <= '0;
         rep_q       <= '0;
         tmo_q       <= '0;
         rep_en_q    <= 1'b0;
         dirty_q     <= 1'b0;
         run_en_q    <= 1'b1;
         sec_clear_q <= 1'b0;
         inc_q       <= 4'b0000;
`ifdef CLOCK_SET_BLINK_EN
         phase_q     <= 1'b1;
         blink_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         mode_d1     <= bus.key_mode_n;
         mode_d2     <= mode_d1;
         add_d1      <= bus.key_add_n;
         add_d2      <= add_d1;
         mode_arm_q  <= mode_arm_q | bus.key_mode_n;
         add_arm_q   <= add_arm_q | bus.key_add_n;
         hold_q      <= hold_d;
         rep_q       <= rep_d;
         tmo_q       <= tmo_d;
         rep_en_q    <= rep_en_d;
         dirty_q     <= dirty_d;
         run_en_q    <= run_en_d;
         sec_clear_q <= sec_clear_d;
         inc_q       <= inc_d;
`ifdef CLOCK_SET_BLINK_EN
         phase_q     <= phase_d;
         blink_q     <= blink_d;
`endif
      end
   end

   assign bus.status     = state_q;
   assign bus.run_en     = run_en_q;
   assign bus.sec_clear  = sec_clear_q;
   assign bus.inc_minute = inc_q[0];
   assign bus.inc_hour   = inc_q[1];
   assign bus.inc_day    = inc_q[2];
   assign bus.inc_month  = inc_q[3];
   assign bus.digit_mask = mask_out;

endmodule

// File: tb/tb_clock_set_sequencer.sv
// tb/tb_clock_set_sequencer.sv - self-checking bench for clock_set_sequencer
`timescale 1ns/1ps
module tb_clock_set_sequencer;
   localparam int HOLD    = 50;
   localparam int REPEAT  = 10;
   localparam int TIMEOUT = 1000;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   clock_set_sequencer_if bus();

   clock_set_sequencer dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int tests = 0;
   int fails = 0;

   // Behavioural model: mode index, idle tick count, ticks held since the ADD press.
   int         m_state  = 0;
   int         m_idle   = 0;
   int         m_held   = 0;
   bit         m_rep    = 0;
   bit         m_dirty  = 0;
   bit         m_run_en = 1;
   logic [3:0] m_inc    = 4'b0000;   // {month, day, hour, minute}
   logic       m_sc     = 1'b0;
   int         pm1 = -1, pm2 = -1, pa1 = -1, pa2 = -1;   // sampled key levels, -1 = none since reset

   int n_min = 0, n_hour = 0, n_day = 0, n_month = 0, n_sc = 0;

   function automatic logic [3:0] inc_for(input int s);
      case (s)
         1: return 4'b0010;
         2: return 4'b0001;
         3: return 4'b1000;
         4: return 4'b0100;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [3:0] mask_for(input int s);
      logic [3:0] tbl [5];
      tbl = '{4'b1111, 4'b1100, 4'b0011, 4'b1100, 4'b0011};
      return tbl[s];
   endfunction

   task automatic model_leave();
      m_state  = 0;
      m_run_en = 1;
      m_sc     = m_dirty;
      m_dirty  = 0;
      m_rep    = 0;
      m_idle   = 0;
      m_inc    = 4'b0000;
   endtask

   task automatic model_step();
      bit mp, ap, held;
      m_inc = 4'b0000;
      m_sc  = 1'b0;
      mp    = (pm1 == 0) && (pm2 == 1);
      ap    = (pa1 == 0) && (pa2 == 1);
      held  = (pa1 == 0);
      if (!held) m_rep = 0;
      if (mp) begin
         m_rep  = 0;
         m_idle = 0;
         if (m_state == 4) model_leave();
         else m_state = m_state + 1;
      end else if (m_state != 0) begin
         if (ap) begin
            m_inc    = inc_for(m_state);
            m_dirty  = 1;
            m_run_en = 0;
            m_rep    = 1;
            m_held   = 0;
            m_idle   = 0;
         end else if (bus.tick_10ms) begin
            m_idle = m_idle + 1;
            if (m_rep) begin
               m_held = m_held + 1;
               if (m_held == HOLD || (m_held > HOLD && (m_held - HOLD) % REPEAT == 0))
                  m_inc = inc_for(m_state);
            end
            if (m_idle == TIMEOUT) model_leave();
         end
      end
      pm2 = pm1;
      pm1 = int'(bus.key_mode_n);
      pa2 = pa1;
      pa1 = int'(bus.key_add_n);
   endtask

   initial begin
      forever begin
         @(posedge clock or posedge reset);
         if (reset) begin
            m_state = 0; m_idle = 0; m_held = 0; m_rep = 0; m_dirty = 0; m_run_en = 1;
            m_inc = 4'b0000; m_sc = 1'b0;
            pm1 = -1; pm2 = -1; pa1 = -1; pa2 = -1;
         end else begin
            model_step();
         end
      end
   end

   // Cycle compare against the model, plus DUT pulse tallies for the literal checks.
   initial begin
      logic [3:0] got_inc;
      forever begin
         @(negedge clock);
         got_inc = {bus.inc_month, bus.inc_day, bus.inc_hour, bus.inc_minute};
         tests++;
         if (bus.status !== 3'(m_state) || bus.run_en !== m_run_en || bus.sec_clear !== m_sc ||
             got_inc !== m_inc || bus.digit_mask !== mask_for(m_state)) begin
            fails++;
            $display("FAIL cycle_cmp @%0t: got status=%0d run_en=%0b sec_clear=%0b inc=%b mask=%b, need status=%0d run_en=%0b sec_clear=%0b inc=%b mask=%b",
                     $time, bus.status, bus.run_en, bus.sec_clear, got_inc, bus.digit_mask,
                     m_state, m_run_en, m_sc, m_inc, mask_for(m_state));
         end
         n_min   += int'(bus.inc_minute);
         n_hour  += int'(bus.inc_hour);
         n_day   += int'(bus.inc_day);
         n_month += int'(bus.inc_month);
         n_sc    += int'(bus.sec_clear);
      end
   end

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, need %0d", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic press_mode();
      bus.key_mode_n = 1'b0; cyc(3);
      bus.key_mode_n = 1'b1; cyc(3);
   endtask

   task automatic tap_add();
      bus.key_add_n = 1'b0; cyc(3);
      bus.key_add_n = 1'b1; cyc(3);
   endtask

   task automatic ticks(input int n);
      repeat (n) begin
         bus.tick_10ms = 1'b1; cyc(1);
         bus.tick_10ms = 1'b0; cyc(1);
      end
   endtask

   function automatic int inc_total();
      return n_min + n_hour + n_day + n_month;
   endfunction

   initial begin
      int s_inc, s_sc, s_min, s_hour, s_day;
      int walk [5];
      walk = '{1, 2, 3, 4, 0};
      bus.tick_10ms  = 1'b0;
      bus.key_mode_n = 1'b1;
      bus.key_add_n  = 1'b1;
      reset = 1'b1;
      cyc(3);

      // T1 reset values
      check("t1_status", int'(bus.status), 0);
      check("t1_run_en", int'(bus.run_en), 1);
      check("t1_mask", int'(bus.digit_mask), 15);
      check("t1_inc", int'({bus.inc_month, bus.inc_day, bus.inc_hour, bus.inc_minute}), 0);
      check("t1_sec_clear", int'(bus.sec_clear), 0);
      reset = 1'b0;
      cyc(2);

      // T2 mode walk, nothing dirty
      s_inc = inc_total(); s_sc = n_sc;
      for (int i = 0; i < 5; i++) begin
         press_mode();
         check("t2_status", int'(bus.status), walk[i]);
      end
      check("t2_no_inc", inc_total() - s_inc, 0);
      check("t2_no_sec_clear", n_sc - s_sc, 0);

      // T3 set minute
      press_mode(); press_mode();
      s_min = n_min;
      tap_add();
      check("t3_inc_minute", n_min - s_min, 1);
      check("t3_run_en_low", int'(bus.run_en), 0);
      s_sc = n_sc;
      press_mode(); press_mode(); press_mode();
      check("t3_status_run", int'(bus.status), 0);
      check("t3_run_en_high", int'(bus.run_en), 1);
      check("t3_sec_clear", n_sc - s_sc, 1);

      // T4 auto-repeat in SET_HOUR
      press_mode();
      s_hour = n_hour;
      bus.key_add_n = 1'b0; cyc(4);
      check("t4_first", n_hour - s_hour, 1);
      ticks(120);
      check("t4_held_total", n_hour - s_hour, 9);
      bus.key_add_n = 1'b1; cyc(3);
      ticks(30);
      check("t4_after_release", n_hour - s_hour, 9);
      press_mode(); press_mode(); press_mode(); press_mode();
      check("t4_back_run", int'(bus.status), 0);

      // T5 timeout from SET_DAY
      press_mode(); press_mode(); press_mode(); press_mode();
      check("t5_in_day", int'(bus.status), 4);
      s_day = n_day; s_sc = n_sc;
      tap_add();
      ticks(999);
      check("t5_before_timeout", int'(bus.status), 4);
      ticks(1);
      check("t5_timeout_status", int'(bus.status), 0);
      check("t5_run_en", int'(bus.run_en), 1);
      check("t5_inc_day", n_day - s_day, 1);
      check("t5_sec_clear", n_sc - s_sc, 1);

      // T6 simultaneous MODE+ADD, then reset during a held ADD
      press_mode();
      s_inc = inc_total();
      bus.key_mode_n = 1'b0; bus.key_add_n = 1'b0; cyc(3);
      bus.key_mode_n = 1'b1; bus.key_add_n = 1'b1; cyc(3);
      check("t6_conflict_status", int'(bus.status), 2);
      check("t6_conflict_no_inc", inc_total() - s_inc, 0);
      bus.key_add_n = 1'b0; cyc(4);
      ticks(30);
      reset = 1'b1; cyc(2);
      check("t6_reset_status", int'(bus.status), 0);
      check("t6_reset_mask", int'(bus.digit_mask), 15);
      reset = 1'b0; cyc(2);
      press_mode();
      check("t6_held_into_hour", int'(bus.status), 1);
      s_inc = inc_total();
      ticks(70);
      check("t6_no_inc_held", inc_total() - s_inc, 0);
      bus.key_add_n = 1'b1; cyc(3);
      s_hour = n_hour;
      tap_add();
      check("t6_new_press", n_hour - s_hour, 1);
      cyc(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
